// File: rtl/axi_ar_rr_arbiter.sv
// axi_ar_rr_arbiter: shares one AXI4 read-address target port among N_MASTER
// requesters. Round-robin grant, held stable until the AR handshake, requester
// index prepended to the forwarded ARID, and a credit counter that caps the
// number of reads in flight to the target (decremented on final R beats).
module axi_ar_rr_arbiter #(
   parameter int N_MASTER        = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int INFO_WIDTH      = 29,
   parameter int MAX_OUTSTANDING = 8,
   // Set to 0 to silence the credit-underflow simulation check.
   parameter bit UNDERFLOW_CHECK = 1'b1,
   localparam int MIDX_W = (N_MASTER > 2) ? $clog2(N_MASTER) : 1,
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_MASTER-1:0]              arvalid_i,
   input  logic [N_MASTER*ADDR_WIDTH-1:0]   araddr_i,
   input  logic [N_MASTER*ID_WIDTH-1:0]     arid_i,
   input  logic [N_MASTER*INFO_WIDTH-1:0]   arinfo_i,
   output logic [N_MASTER-1:0]              arready_o,
   output logic                             arvalid_o,
   output logic [ADDR_WIDTH-1:0]            araddr_o,
   output logic [ID_WIDTH+MIDX_W-1:0]       arid_o,
   output logic [INFO_WIDTH-1:0]            arinfo_o,
   input  logic                             arready_i,
   input  logic                             rlast_done_i,
   output logic [CNT_W-1:0]                 outstanding_o,
   output logic                             full_o
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(N_MASTER - 1);

   // Registered state
   logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic              lock_q, lock_d;
   logic [MIDX_W-1:0] lock_idx_q, lock_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Combinational arbitration signals
   logic [MIDX_W-1:0] hi_idx, lo_idx, scan_idx, grant;
   logic              hi_found, lo_found;
   logic              sel_valid;
   logic              hs;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ID_WIDTH-1:0]   sel_id;
   logic [INFO_WIDTH-1:0] sel_info;

   // Unpacked per-lane views of the flattened request buses
   logic [ADDR_WIDTH-1:0] addr_lane [N_MASTER];
   logic [ID_WIDTH-1:0]   id_lane   [N_MASTER];
   logic [INFO_WIDTH-1:0] info_lane [N_MASTER];

   generate
      for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_lane
         assign addr_lane[gi] = araddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign id_lane[gi]   = arid_i[gi*ID_WIDTH +: ID_WIDTH];
         assign info_lane[gi] = arinfo_i[gi*INFO_WIDTH +: INFO_WIDTH];
      end
   endgenerate

   // Round-robin search: lowest requesting index at or above the pointer wins,
   // otherwise the lowest requesting index below it (the wrap-around half).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int k = N_MASTER - 1; k >= 0; k--) begin
         if (arvalid_i[k]) begin
            if (MIDX_W'(k) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = MIDX_W'(k);
            end else begin
               lo_found = 1'b1;
               lo_idx   = MIDX_W'(k);
            end
         end
      end
      scan_idx = hi_found ? hi_idx : (lo_found ? lo_idx : '0);
   end

   // A locked grant overrides the search until its handshake completes
   always_comb begin
      grant = lock_q ? lock_idx_q : scan_idx;
   end

   // Steer the granted lane onto the target port
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_id    = '0;
      sel_info  = '0;
      for (int k = 0; k < N_MASTER; k++) begin
         if (grant == MIDX_W'(k)) begin
            sel_valid = arvalid_i[k];
            sel_addr  = addr_lane[k];
            sel_id    = id_lane[k];
            sel_info  = info_lane[k];
         end
      end
   end

   // Full comes from the registered count only, so it never drops a presented
   // request: reaching full needs a handshake, which also retires that request.
   assign full_o        = (cnt_q == CNT_MAX);
   assign outstanding_o = cnt_q;
   assign arvalid_o     = sel_valid & ~full_o;
   assign araddr_o      = sel_addr;
   assign arid_o        = {grant, sel_id};
   assign arinfo_o      = sel_info;
   assign hs            = arvalid_o & arready_i;

   generate
      for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_ready
         assign arready_o[gi] = (grant == MIDX_W'(gi)) & hs;
      end
   endgenerate

   // Next-state: lock, round-robin pointer and credit counter
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;

      if (hs) begin
         lock_d   = 1'b0;
         rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + MIDX_W'(1);
      end else if (arvalid_o) begin
         // Presented but stalled: pin the grant so AR stays stable.
         lock_d     = 1'b1;
         lock_idx_d = grant;
      end
      // A withdrawn locked request leaves the lock untouched (falls through).

      if (hs && !rlast_done_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!hs && rlast_done_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   generate
      if (UNDERFLOW_CHECK) begin : g_underflow_chk
         // Flag a final R beat arriving with no read outstanding
         always_ff @(posedge clk) begin
            if (!rst && rlast_done_i) begin
               assert (cnt_q != '0)
                  else $error("axi_ar_rr_arbiter: rlast_done_i with no outstanding read");
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Bench for axi_ar_rr_arbiter: directed steps followed by randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_axi_ar_rr_arbiter;

   localparam int N    = 4;
   localparam int AW   = 32;
   localparam int IW   = 4;
   localparam int INW  = 29;
   localparam int MAXO = 8;
   localparam int MW   = 2;
   localparam int CW   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      arvalid_i;
   logic [N*AW-1:0]   araddr_i;
   logic [N*IW-1:0]   arid_i;
   logic [N*INW-1:0]  arinfo_i;
   logic [N-1:0]      arready_o;
   logic              arvalid_o;
   logic [AW-1:0]     araddr_o;
   logic [IW+MW-1:0]  arid_o;
   logic [INW-1:0]    arinfo_o;
   logic              arready_i;
   logic              rlast_done_i;
   logic [CW-1:0]     outstanding_o;
   logic              full_o;

   axi_ar_rr_arbiter #(
      .N_MASTER(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .INFO_WIDTH(INW),
      .MAX_OUTSTANDING(MAXO), .UNDERFLOW_CHECK(1'b0)
   ) dut (
      .clk(clk), .rst(rst),
      .arvalid_i(arvalid_i), .araddr_i(araddr_i), .arid_i(arid_i), .arinfo_i(arinfo_i),
      .arready_o(arready_o), .arvalid_o(arvalid_o), .araddr_o(araddr_o),
      .arid_o(arid_o), .arinfo_o(arinfo_o), .arready_i(arready_i),
      .rlast_done_i(rlast_done_i), .outstanding_o(outstanding_o), .full_o(full_o)
   );

   always #5 clk = ~clk;

   // Requester-side stimulus state
   bit            lane_v    [N];
   logic [AW-1:0] lane_addr [N];
   logic [IW-1:0] lane_id   [N];
   logic [INW-1:0] lane_info [N];

   // Reference model state
   int m_ptr, m_lock, m_idx, m_cnt;

   // Observations captured at the last sample point
   logic          obs_valid, obs_full;
   logic [N-1:0]  obs_ready;
   logic [IW+MW-1:0] obs_arid;
   logic [AW-1:0] obs_addr;
   logic [CW-1:0] obs_cnt;

   int vectors = 0;
   int miscompares = 0;
   bit auto_clear = 1'b0;
   bit check_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   function automatic int exp_grant();
      if (m_lock != 0) return m_idx;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (arvalid_i[k]) return k;
      end
      return 0;
   endfunction

   // One clock: drive, sample and compare mid-cycle, then advance the model.
   task automatic cycle();
      int g;
      bit ev;
      bit hs;
      logic [1:0] g2;
      for (int k = 0; k < N; k++) begin
         arvalid_i[k]             = lane_v[k];
         araddr_i[k*AW +: AW]     = lane_addr[k];
         arid_i[k*IW +: IW]       = lane_id[k];
         arinfo_i[k*INW +: INW]   = lane_info[k];
      end
      #4;
      g  = exp_grant();
      g2 = g[1:0];
      ev = arvalid_i[g] && (m_cnt != MAXO);
      hs = ev && arready_i;
      obs_valid = arvalid_o; obs_ready = arready_o; obs_arid = arid_o;
      obs_addr  = araddr_o;  obs_cnt   = outstanding_o; obs_full = full_o;
      if (check_en) begin
         check("arvalid_o", arvalid_o, ev);
         check("arready_o", arready_o, hs ? (64'd1 << g) : 64'd0);
         check("arid_o", arid_o, {g2, lane_id[g]});
         check("araddr_o", araddr_o, lane_addr[g]);
         check("arinfo_o", arinfo_o, lane_info[g]);
         check("outstanding_o", outstanding_o, m_cnt);
         check("full_o", full_o, m_cnt == MAXO);
      end
      $display("t=%0t rst=%0b req=%b rdy_i=%0b rl=%0b | grant=%0d valid=%0b ready=%b cnt=%0d",
               $time, rst, arvalid_i, arready_i, rlast_done_i, g, arvalid_o, arready_o, outstanding_o);
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_lock = 0; m_idx = 0; m_cnt = 0;
         if (auto_clear) for (int k = 0; k < N; k++) lane_v[k] = 1'b0;
      end else if (hs) begin
         m_ptr  = (g + 1) % N;
         m_lock = 0;
         if (!rlast_done_i) m_cnt++;
         if (auto_clear) lane_v[g] = 1'b0;
      end else begin
         if (ev) begin
            m_lock = 1;
            m_idx  = g;
         end
         if (rlast_done_i && m_cnt > 0) m_cnt--;
      end
      #1;
   endtask

   task automatic clear_lanes();
      for (int k = 0; k < N; k++) lane_v[k] = 1'b0;
   endtask

   task automatic drain(input int n);
      clear_lanes();
      rlast_done_i = 1'b1;
      for (int i = 0; i < n; i++) cycle();
      rlast_done_i = 1'b0;
   endtask

   initial begin
      m_ptr = 0; m_lock = 0; m_idx = 0; m_cnt = 0;
      rst = 1'b1; arready_i = 1'b0; rlast_done_i = 1'b0;
      for (int k = 0; k < N; k++) begin
         lane_v[k]    = 1'b0;
         lane_addr[k] = 32'h0000_1000 * (k + 1);
         lane_id[k]   = IW'(k + 8);
         lane_info[k] = INW'(29'h100 + k);
      end
      #1;
      // Reset: first edge initialises the DUT; afterwards everything is checked.
      cycle();
      check_en = 1'b1;
      cycle();
      check("reset_cnt", obs_cnt, 0);
      check("reset_full", obs_full, 0);
      check("reset_valid", obs_valid, 0);
      check("reset_ready", obs_ready, 0);
      rst = 1'b0;

      // Round robin with all requesters continuously valid
      for (int k = 0; k < N; k++) lane_v[k] = 1'b1;
      arready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("rr_grant", obs_arid[IW +: MW], i % N);
         check("rr_onehot", $countones(obs_ready), 1);
      end
      clear_lanes();

      // Stall with lock on requester 2 while requester 1 arrives
      lane_v[2] = 1'b1; lane_addr[2] = 32'h1000_0040; lane_id[2] = 4'h5;
      arready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) lane_v[1] = 1'b1;
         cycle();
         check("lock_valid", obs_valid, 1);
         check("lock_arid", obs_arid, 6'h25);
         check("lock_addr", obs_addr, 32'h1000_0040);
      end
      arready_i = 1'b1;
      cycle();
      check("lock_ready", obs_ready, 4'b0100);
      check("lock_hs_arid", obs_arid, 6'h25);
      lane_v[2] = 1'b0;
      cycle();
      check("after_lock_grant", obs_arid[IW +: MW], 1);
      clear_lanes();

      // Drain credits back to zero
      drain(7);
      cycle();
      check("drained", obs_cnt, 0);

      // Fill to MAX_OUTSTANDING, block, then release with one final R beat
      for (int k = 0; k < N; k++) lane_v[k] = 1'b1;
      arready_i = 1'b1;
      for (int i = 0; i < MAXO; i++) cycle();
      cycle();
      check("full_flag", obs_full, 1);
      check("full_blocks", obs_valid, 0);
      rlast_done_i = 1'b1;
      cycle();
      check("full_same_cycle", obs_full, 1);
      check("full_same_cycle_valid", obs_valid, 0);
      rlast_done_i = 1'b0;
      cycle();
      check("unfull_flag", obs_full, 0);
      check("unfull_accept", obs_valid, 1);
      clear_lanes();

      // Handshake and final R beat together at cnt=1
      drain(7);
      lane_v[0] = 1'b1; arready_i = 1'b1; rlast_done_i = 1'b1;
      cycle();
      check("both_pre", obs_cnt, 1);
      lane_v[0] = 1'b0; rlast_done_i = 1'b0;
      cycle();
      check("both_post", obs_cnt, 1);

      // Reset while requester 3 is locked with five reads in flight
      lane_v[0] = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      lane_v[0] = 1'b0; lane_v[3] = 1'b1; arready_i = 1'b0;
      cycle();
      check("pre_rst_cnt", obs_cnt, 5);
      rst = 1'b1;
      cycle();
      rst = 1'b0; lane_v[1] = 1'b1; arready_i = 1'b1;
      cycle();
      check("post_rst_cnt", obs_cnt, 0);
      check("post_rst_grant", obs_arid[IW +: MW], 1);
      check("post_rst_ready", obs_ready, 4'b0010);
      clear_lanes();

      // Final R beat with nothing outstanding saturates at zero
      drain(1);
      rlast_done_i = 1'b1;
      cycle();
      rlast_done_i = 1'b0;
      cycle();
      check("underflow_sat", obs_cnt, 0);

      // Randomized traffic
      auto_clear = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         rst          = ($urandom_range(99) == 0);
         arready_i    = ($urandom_range(3) != 0);
         rlast_done_i = ($urandom_range(2) == 0);
         for (int k = 0; k < N; k++) begin
            if (!lane_v[k] && $urandom_range(2) == 0) begin
               lane_v[k]    = 1'b1;
               lane_addr[k] = $urandom;
               lane_id[k]   = IW'($urandom_range(15));
               lane_info[k] = INW'($urandom);
            end else if (lane_v[k] && $urandom_range(59) == 0) begin
               lane_v[k] = 1'b0;
            end
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_ar_rr_arbiter.md
Name: axi_ar_rr_arbiter

Overview:
- Shares one AXI4 read-address target port among N_MASTER requesters with round-robin arbitration.
- Sits downstream of the per-initiator AR address decoders: each decoder's per-target arvalid bit becomes one request lane here.
- Holds the grant stable until the AR handshake completes.
- Tags each forwarded ID with the requester index so R routing can recover the source.
- Caps outstanding reads to the target with a credit counter that decrements on final R beats.

Parameters:
- N_MASTER, 4, number of requesting initiators (>=2).
- ADDR_WIDTH, 32, AR address width.
- ID_WIDTH, 4, incoming ARID width.
- INFO_WIDTH, 29, packed ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARREGION/ARQOS; forwarded untouched.
- MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted reads (>=1).
- Derived: MIDX_W = max(1, clog2(N_MASTER)); CNT_W = clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- arvalid_i  in  N_MASTER  per-requester AR valid.
- araddr_i  in  N_MASTER*ADDR_WIDTH  per-requester address; lane k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- arid_i  in  N_MASTER*ID_WIDTH  per-requester ID.
- arinfo_i  in  N_MASTER*INFO_WIDTH  per-requester packed attributes.
- arready_o  out  N_MASTER  per-requester ready.
- arvalid_o  out  1  target AR valid.
- araddr_o  out  ADDR_WIDTH  selected address.
- arid_o  out  ID_WIDTH+MIDX_W  {grant index, selected arid}; index in MSBs.
- arinfo_o  out  INFO_WIDTH  selected attributes.
- arready_i  in  1  target AR ready.
- rlast_done_i  in  1  one-cycle pulse: R handshake with RLAST=1 on this target.
- outstanding_o  out  CNT_W  current outstanding count.
- full_o  out  1  outstanding_o == MAX_OUTSTANDING.

Behaviour:
- Registered state: rr_ptr (MIDX_W), lock_q (1), lock_idx_q (MIDX_W), cnt_q (CNT_W).
- Reset (rst=1 at clk edge): rr_ptr=0, lock_q=0, lock_idx_q=0, cnt_q=0.
  - Hence arvalid_o=0 unless a request is present.
  - arready_o=0.
  - outstanding_o=0.
  - full_o=0.
- Reset mid-transfer discards the lock and all credits; no state survives.
- Grant selection, combinational, same cycle:
  - If lock_q=1: grant = lock_idx_q.
  - Otherwise: grant = first k with arvalid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_MASTER.
  - No request and not locked: grant = 0.
- Output gating:
  - arvalid_o = arvalid_i[grant] & ~full_o.
  - araddr_o/arid_o/arinfo_o = lane[grant] fields, always driven; don't-care when arvalid_o=0.
- Ready: arready_o[k] = (k==grant) & arvalid_o & arready_i. At most one bit is set.
- Handshake hs = arvalid_o & arready_i. Latency is zero cycles from request to arvalid_o when the target is idle.
- Lock rule:
  - If arvalid_o=1 and arready_i=0: set lock_q=1 and lock_idx_q=grant.
  - On hs: clear lock_q.
  - If the locked requester drops arvalid_i (protocol violation), arvalid_o falls to 0 and lock_q stays set until that requester's handshake.
- Pointer rule: on hs, rr_ptr <= (grant+1) mod N_MASTER. Otherwise unchanged.
- Credit counter:
  - hs only: cnt+1.
  - rlast_done_i only: cnt-1.
  - Both in the same cycle: unchanged.
  - rlast_done_i with cnt_q=0 is ignored (saturate at 0); simulation assertion fires.
  - hs cannot occur when full, so no overflow.
- Full handling:
  - full_o is derived from registered cnt_q only; same-cycle rlast_done_i does not unblock.
  - Full is reached only after a handshake, so it never withdraws an already-presented arvalid_o.
- Non-power-of-two N_MASTER: pointer wraps at N_MASTER-1 → 0; indices >= N_MASTER are never granted.

Test Plan:
- N_MASTER=4, requesters 0..3 continuously valid, arready_i=1 → grants 0,1,2,3,0 on consecutive cycles; arid_o MSBs follow 0,1,2,3,0; one arready_o bit per cycle.
- Requester 2 valid with araddr=0x1000_0040, arid=0x5, arready_i held 0 for 3 cycles while requester 1 rises in cycle 2 → arvalid_o held, grant stays 2 with stable araddr_o; cycle 4 arready_i=1 → arready_o=4'b0100, arid_o={2'd2,4'h5}; next grant is 1.
- MAX_OUTSTANDING=2, three back-to-back requests, no rlast_done_i → two handshakes, then full_o=1 and arvalid_o=0; one rlast_done_i pulse → full_o=0 next cycle and the third request is accepted.
- Handshake and rlast_done_i in the same cycle with cnt=1 → outstanding_o stays 1.
- rst asserted while requester 3 is locked with cnt=5 → next cycle rr_ptr=0, cnt=0, lock cleared; requesters 1 and 3 valid → grant 1.
- rlast_done_i with cnt=0 → outstanding_o stays 0 and the assertion reports.
